// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response and data_memory bus of the two-port arbiter
// slave is the arbiter's view; master is the requesters' plus memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0]            req_we;
   logic [ADDR_WIDTH-1:0] req_addr0;
   logic [ADDR_WIDTH-1:0] req_addr1;
   logic [DATA_WIDTH-1:0] req_wdata0;
   logic [DATA_WIDTH-1:0] req_wdata1;
   logic [1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer in front of single-port data_memory
// One access per IDLE->ACCESS round trip; memory strobes are flops so async reset drops them at once.
module dmem_arbiter #(
   parameter int          ADDR_WIDTH     = 32,
   parameter int          DATA_WIDTH     = 32,
   parameter int unsigned FIXED_PRIORITY = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);
   typedef enum logic {IDLE, ACCESS} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  port_q, port_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]            rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  grant;
   logic                  accept;

   // With both ports pending, round-robin hands the slot to the port that did not win last time.
   always_comb begin
      grant = 1'b0;
      if (bus.req_valid == 2'b11) begin
         grant = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
      end else begin
         grant = bus.req_valid[1];
      end
   end

   assign accept        = (state_q == IDLE) && (bus.req_valid != 2'b00);
   assign bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rsp_valid_d  = 2'b00;
      rsp_rdata_d  = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = ACCESS;
               last_grant_d = grant;
               port_d       = grant;
               mem_addr_d   = grant ? bus.req_addr1  : bus.req_addr0;
               mem_wdata_d  = grant ? bus.req_wdata1 : bus.req_wdata0;
               mem_write_d  = bus.req_we[grant];
               mem_read_d   = ~bus.req_we[grant];
            end
         end
         ACCESS: begin
            state_d     = IDLE;
            rsp_valid_d = port_q ? 2'b10 : 2'b01;
            // Write acks leave the last read data visible.
            if (mem_read_q) begin
               rsp_rdata_d = bus.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rsp_valid_q  <= 2'b00;
         rsp_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule
